lfsr_gen: RTL

LFSR_GEN -- requirements
Module: lfsr_gen

---
 rtl/lfsr_gen_pkg.sv | 14 +
 rtl/lfsr_gen_step.sv | 14 +
 rtl/lfsr_gen.sv | 104 ++++++++++
 3 files changed

// File: rtl/lfsr_gen_pkg.sv
// Shared types and default tap masks for the Galois LFSR generator.
package lfsr_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Maximal-length Galois tap masks for common widths
    localparam logic [7:0]  TAPS_W8  = 8'h1D;
    localparam logic [15:0] TAPS_W16 = 16'h100B;
    localparam logic [31:0] TAPS_W32 = 32'h000000C5;

endpackage

// File: rtl/lfsr_gen_step.sv
// One Galois LFSR step: shift left, fold the tap mask in when the MSB falls out.
module lfsr_gen_step #(
    parameter int unsigned          WIDTH = 8,
    parameter logic [WIDTH-1:0]     TAPS  = 8'h1D
) (
    input  logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] s_next
);

    always_comb begin
        s_next = {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? TAPS : '0);
    end

endmodule

// File: rtl/lfsr_gen.sv
// Galois LFSR generator with valid/ready handshake, seed load and zero-seed lockup guard.
// Optional period checker (wrap pulse) is built when LFSR_GEN_PERIOD_CHK_EN is defined.
module lfsr_gen
    import lfsr_gen_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = TAPS_W8,
    parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             ready,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             lockup,
    output logic             wrap
);

    state_t           state;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] load_val;
    logic             seed_zero;
    logic             advance;

    lfsr_gen_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_step (
        .s      (q),
        .s_next (q_next)
    );

    // A zero seed would freeze the register forever, so it is replaced by SEED
    always_comb begin
        seed_zero = (seed == '0);
        load_val  = seed_zero ? SEED : seed;
        advance   = valid & ready;
    end

    always_ff @(posedge clock) begin
        lockup <= 1'b0;
        if (reset) begin
            state <= IDLE;
            valid <= 1'b0;
            q     <= SEED;
        end else if (load) begin
            state  <= IDLE;
            valid  <= 1'b0;
            q      <= load_val;
            lockup <= seed_zero;
        end else begin
            if (advance) begin
                q <= q_next;
            end
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= RUN;
                        valid <= 1'b1;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state <= IDLE;
                        valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef LFSR_GEN_PERIOD_CHK_EN
    logic [WIDTH-1:0] start_q;
    logic [WIDTH-1:0] steps;

    always_ff @(posedge clock) begin
        wrap <= 1'b0;
        if (reset) begin
            start_q <= SEED;
            steps   <= '0;
        end else if (load) begin
            start_q <= load_val;
            steps   <= '0;
        end else if (advance) begin
            if (q_next == start_q) begin
                wrap  <= 1'b1;
                steps <= '0;
            end else begin
                steps <= steps + 1'b1;
            end
        end
    end
`else
    assign wrap = 1'b0;
`endif

endmodule
